binary_fibonacci: RTL and testbench
===================================

BINARY_FIBONACCI -- requirements
Module: binary_fibonacci

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 en_convert  input  1  start request, sampled only in IDLE.
REQ-005 input_b  input  16  unsigned binary value to encode, sampled with en_convert.
REQ-006 busy  output  1  high while a conversion is in progress (SCAN state).
REQ-007 convert_done  output  1  one-cycle pulse marking f_b_out updated.
REQ-008 f_b_out  output  32  Zeckendorf code; bit k weights FIB[k]; bits 31..23 always 0.

Function
REQ-009 SHALL use weights FIB[0..22] = 1,2,3,5,8,...,28657,46368; FIB[k]=FIB[k-1]+FIB[k-2] for k>=2.
REQ-010 SHALL implement FSM states IDLE, SCAN, DONE, plus working registers rem[15:0], idx[4:0] and code[22:0].
REQ-011 IDLE: en_convert=1 at edge E SHALL load rem<=input_b, idx<=22, code<=0 and go to SCAN; en_convert=0 SHALL hold IDLE.
REQ-012 SCAN, one digit per cycle: if rem>=FIB[idx], SHALL set code[idx] and rem<=rem-FIB[idx]; otherwise code[idx]=0.
REQ-013 SCAN SHALL run exactly 23 cycles (idx 22 down to 0) regardless of value; there is no early exit.
REQ-014 At idx=0, SHALL register f_b_out<={9'b0, final code} and convert_done<=1 at edge E+23, and go to DONE.
REQ-015 DONE SHALL last one cycle: convert_done<=0 at E+24 and return to IDLE, so a new start is accepted at edge E+24 at the earliest.
REQ-016 f_b_out SHALL hold the previous result throughout SCAN and change only at the done edge.
REQ-017 Output SHALL never contain two adjacent 1 bits (greedy guarantee); rem SHALL equal 0 after idx=0.
REQ-018 en_convert while busy or in DONE SHALL be ignored; input_b changes after the start edge SHALL have no effect.
REQ-019 Arithmetic: the compare and subtract SHALL be 16-bit unsigned; no overflow is possible since every input <= 65535 < FIB[23].
REQ-020 busy SHALL be high exactly in SCAN; busy and convert_done SHALL never be high together.
REQ-021 For any input x, decoding f_b_out by the team's Fibonacci decoder with the same FIB table SHALL return x.

Reset
REQ-022 rst=0 SHALL immediately force state=IDLE, busy=0, convert_done=0, f_b_out=0, rem=0, idx=0, code=0.
REQ-023 Reset during SCAN SHALL abort the conversion with no convert_done pulse; the first start after rst release SHALL behave per REQ-011.

Structure
REQ-024 Shared package fib_pkg SHALL hold FIB_DIGITS=23, BIN_W=16, CODE_W=32, IDX_W=5 and the FSM state encoding.
REQ-025 Sub-module fib_rom SHALL be a combinational lookup (idx[4:0] -> 16-bit FIB[idx]); indices 23..31 SHALL return 0.
REQ-026 Target size SHALL be 120-400 lines of RTL including fib_rom.

Verification
REQ-027 input_b=0, start -> convert_done at E+23, f_b_out=32'h0000_0000.
REQ-028 input_b=1 -> 32'h0000_0001; input_b=4 -> 32'h0000_0005; input_b=100 -> 32'h0000_0214.
REQ-029 input_b=65535 -> 32'h0050_5204 (bits 22,20,14,12,9,2); busy high for 23 cycles; single done pulse.
REQ-030 Start with 100, pulse en_convert at E+5 with input_b=7, then start with 7 at E+24 -> first result 0x214 only; second conversion done at E+47 with 32'h0000_000A.
REQ-031 rst low at E+10 during SCAN -> outputs zero at once, no done pulse; restart with 4 -> 32'h0000_0005.
REQ-032 Random 10k inputs -> no adjacent 1s, bits 31..23 zero, and decoder round-trip equals input.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared widths and FSM encoding for the binary-to-Zeckendorf encoder.
// Pure declarations: no latency and no handshake.
package fib_pkg;
    localparam int FIB_DIGITS = 23;
    localparam int BIN_W      = 16;
    localparam int CODE_W     = 32;
    localparam int IDX_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } fib_state_t;
endpackage

// File: rtl/fib_rom.sv
// Combinational Fibonacci weight table: idx -> FIB[idx], zero beyond the last digit.
// Zero latency, no backpressure.
module fib_rom
    import fib_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [BIN_W-1:0] fib
);

    always_comb begin
        fib = '0;
        case (idx)
            5'd0:  fib = 16'd1;
            5'd1:  fib = 16'd2;
            5'd2:  fib = 16'd3;
            5'd3:  fib = 16'd5;
            5'd4:  fib = 16'd8;
            5'd5:  fib = 16'd13;
            5'd6:  fib = 16'd21;
            5'd7:  fib = 16'd34;
            5'd8:  fib = 16'd55;
            5'd9:  fib = 16'd89;
            5'd10: fib = 16'd144;
            5'd11: fib = 16'd233;
            5'd12: fib = 16'd377;
            5'd13: fib = 16'd610;
            5'd14: fib = 16'd987;
            5'd15: fib = 16'd1597;
            5'd16: fib = 16'd2584;
            5'd17: fib = 16'd4181;
            5'd18: fib = 16'd6765;
            5'd19: fib = 16'd10946;
            5'd20: fib = 16'd17711;
            5'd21: fib = 16'd28657;
            5'd22: fib = 16'd46368;
            default: fib = '0;
        endcase
    end

endmodule

// File: rtl/binary_fibonacci.sv
// Greedy binary -> Zeckendorf encoder, one digit per cycle: result 23 cycles after the start edge.
// Starts are taken only when not busy; a start seen while scanning is dropped.
module binary_fibonacci
    import fib_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_convert,
    input  logic [BIN_W-1:0]  input_b,
    output logic              busy,
    output logic              convert_done,
    output logic [CODE_W-1:0] f_b_out
);

    fib_state_t            state, state_next;
    logic [BIN_W-1:0]      rem;
    logic [IDX_W-1:0]      idx;
    logic [FIB_DIGITS-1:0] code;

    logic [BIN_W-1:0]      fib_val;
    logic                  take;
    logic [BIN_W-1:0]      rem_step;
    logic [FIB_DIGITS-1:0] code_step;
    logic                  load;
    logic                  finish;

    fib_rom u_rom (
        .idx (idx),
        .fib (fib_val)
    );

    assign take      = (rem >= fib_val);
    assign rem_step  = take ? (rem - fib_val) : rem;
    assign code_step = take ? (code | ({{(FIB_DIGITS-1){1'b0}}, 1'b1} << idx)) : code;
    assign busy      = (state == ST_SCAN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_convert) begin
                    load       = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx == '0) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            // DONE's exit edge doubles as the earliest start edge, so back-to-back
            // conversions land exactly 24 cycles apart.
            ST_DONE: begin
                if (en_convert) begin
                    load       = 1'b1;
                    state_next = ST_SCAN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem          <= '0;
            idx          <= '0;
            code         <= '0;
            convert_done <= 1'b0;
            f_b_out      <= '0;
        end else begin
            convert_done <= finish;
            if (load) begin
                rem  <= input_b;
                idx  <= IDX_W'(FIB_DIGITS - 1);
                code <= '0;
            end else if (state == ST_SCAN) begin
                rem  <= rem_step;
                code <= code_step;
                if (idx != '0) begin
                    idx <= idx - 1'b1;
                end
            end
            if (finish) begin
                f_b_out <= {{(CODE_W-FIB_DIGITS){1'b0}}, code_step};
            end
        end
    end

endmodule

// File: tb/tb_binary_fibonacci.sv
// Scoreboard bench for binary_fibonacci: stimulus pushes expected codes, a negedge monitor
// pops and checks value, latency, busy span, pulse shape and Zeckendorf properties.
module tb_binary_fibonacci;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_convert;
    logic [15:0] input_b;
    logic        busy;
    logic        convert_done;
    logic [31:0] f_b_out;

    binary_fibonacci dut (
        .clk          (clk),
        .rst          (rst),
        .en_convert   (en_convert),
        .input_b      (input_b),
        .busy         (busy),
        .convert_done (convert_done),
        .f_b_out      (f_b_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] val;
        logic [31:0] code;
        bit          known;
        int          e;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent decoder: weights built as 1,2,3,5,... by running sums.
    function automatic logic [31:0] decode(input logic [31:0] c);
        int a = 1;
        int b = 2;
        int t;
        int s = 0;
        for (int k = 0; k < 23; k++) begin
            if (c[k]) s += a;
            t = a + b;
            a = b;
            b = t;
        end
        return 32'(s);
    endfunction

    task automatic start(input logic [15:0] v, input logic [31:0] code, input bit known, input bit push);
        exp_t x;
        @(negedge clk);
        en_convert = 1'b1;
        input_b    = v;
        @(posedge clk);
        #1;
        en_convert = 1'b0;
        input_b    = ~v;
        if (push) begin
            x.val = v; x.code = code; x.known = known; x.e = cyc;
            q.push_back(x);
        end
    endtask

    task automatic at_cycle(input int t);
        int n = 0;
        @(negedge clk);
        while (cyc < t && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check(1'b0, "at_cycle_timeout", 32'(cyc), 32'(t));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "done_timeout", 32'(q.size()), 32'd0);
    endtask

    logic [31:0] last_res  = '0;
    int          busy_run  = 0;
    bit          prev_done = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            last_res  = '0;
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy && convert_done) check(1'b0, "busy_with_done", 32'd1, 32'd0);
            if (prev_done) check(convert_done == 1'b0, "done_single_pulse", 32'(convert_done), 32'd0);
            if (busy) begin
                busy_run++;
                if (f_b_out != last_res) check(1'b0, "hold_during_scan", f_b_out, last_res);
            end
            if (convert_done) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_done", f_b_out, 32'd0);
                end else begin
                    e = q.pop_front();
                    if (e.known) check(f_b_out == e.code, "code", f_b_out, e.code);
                    check(cyc == e.e + 23, "done_latency", 32'(cyc), 32'(e.e + 23));
                    check(busy_run == 23, "busy_cycles", 32'(busy_run), 32'd23);
                    check(f_b_out[31:23] == 9'd0, "upper_bits_zero", f_b_out, f_b_out & 32'h007F_FFFF);
                    check((f_b_out & (f_b_out >> 1)) == 32'd0, "no_adjacent_ones", f_b_out, 32'd0);
                    check(decode(f_b_out) == {16'd0, e.val}, "roundtrip", decode(f_b_out), {16'd0, e.val});
                end
                last_res = f_b_out;
                busy_run = 0;
            end
            prev_done = convert_done;
        end
    end

    int e0;

    initial begin
        rst        = 1'b0;
        en_convert = 1'b0;
        input_b    = '0;
        repeat (3) @(negedge clk);
        check(f_b_out == 32'd0, "reset_f_b_out", f_b_out, 32'd0);
        check(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
        check(convert_done == 1'b0, "reset_done", 32'(convert_done), 32'd0);
        rst = 1'b1;

        start(16'd0,     32'h0000_0000, 1'b1, 1'b1); wait_idle();
        start(16'd1,     32'h0000_0001, 1'b1, 1'b1); wait_idle();
        start(16'd4,     32'h0000_0005, 1'b1, 1'b1); wait_idle();
        start(16'd100,   32'h0000_0214, 1'b1, 1'b1); wait_idle();
        start(16'd65535, 32'h0050_5204, 1'b1, 1'b1); wait_idle();
        start(16'd7,     32'h0000_000A, 1'b1, 1'b1); wait_idle();
        start(16'd12,    32'h0000_0015, 1'b1, 1'b1); wait_idle();

        // Start ignored mid-scan, then a back-to-back start on the earliest legal edge.
        start(16'd100, 32'h0000_0214, 1'b1, 1'b1);
        e0 = cyc;
        at_cycle(e0 + 4);
        en_convert = 1'b1;
        input_b    = 16'd7;
        @(posedge clk);
        #1;
        en_convert = 1'b0;
        input_b    = 16'h1234;
        at_cycle(e0 + 23);
        en_convert = 1'b1;
        input_b    = 16'd7;
        @(posedge clk);
        #1;
        en_convert = 1'b0;
        input_b    = 16'hBEEF;
        begin
            exp_t x;
            x.val = 16'd7; x.code = 32'h0000_000A; x.known = 1'b1; x.e = cyc;
            q.push_back(x);
        end
        wait_idle();

        // Reset mid-scan: outputs clear at once and no done pulse follows.
        check(f_b_out == 32'h0000_000A, "result_before_reset", f_b_out, 32'h0000_000A);
        start(16'd65535, 32'd0, 1'b0, 1'b0);
        e0 = cyc;
        at_cycle(e0 + 10);
        rst = 1'b0;
        #1;
        check(f_b_out == 32'd0, "async_reset_f_b_out", f_b_out, 32'd0);
        check(busy == 1'b0, "async_reset_busy", 32'(busy), 32'd0);
        check(convert_done == 1'b0, "async_reset_done", 32'(convert_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check(busy == 1'b0, "idle_after_abort", 32'(busy), 32'd0);
        start(16'd4, 32'h0000_0005, 1'b1, 1'b1); wait_idle();

        for (int i = 0; i < 300; i++) begin
            start(16'($urandom_range(0, 65535)), 32'd0, 1'b0, 1'b1);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check(q.size() == 0, "queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
